distance_sort_oet: RTL and testbench

Iterative odd-even transposition sorter for the KNN datapath. It accepts a packed array of 2^L distances with their class types on a done_calc pulse. It sorts the array in place, one compare/swap phase per clock, in ascending or descending order selected at run time. It exits early once the array is stable and returns the sorted arrays with a one-cycle valid_sort strobe, a phase count and an overrun flag for starts that were dropped.

---
 rtl/distance_sort_oet.sv | 134 +++++++++++++
 tb/tb_distance_sort_oet.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distance_sort_oet.sv
// Iterative odd-even transposition sorter for the KNN datapath: one compare/swap
// phase per clock, run-time ascending/descending order, early exit once stable.
module distance_sort_oet #(
   parameter int L      = 2,
   parameter int W      = 32,
   parameter int TYPE_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      done_calc,
   input  logic                      descend,
   input  logic [W*(1<<L)-1:0]       distance_array,
   input  logic [TYPE_W*(1<<L)-1:0]  type_array,
   output logic [W*(1<<L)-1:0]       distance_array_sorted,
   output logic [TYPE_W*(1<<L)-1:0]  type_array_sorted,
   output logic                      valid_sort,
   output logic                      busy,
   output logic [L:0]                sort_cycles,
   output logic                      overrun
);

   localparam int N = 1 << L;
   localparam logic [L:0] C_N = (L+1)'(N);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SORT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [W-1:0]      r_d [N];
   logic [TYPE_W-1:0] r_t [N];
   logic              r_desc;
   logic [L:0]        r_cnt;
   logic              r_prev_zero;

   logic [W-1:0]      w_d_nxt [N];
   logic [TYPE_W-1:0] w_t_nxt [N];
   logic              w_swap;
   logic [L:0]        w_cnt_nxt;
   logic              w_exit;

   // One transposition phase: pairs start at even indices on even phases, odd otherwise.
   always_comb begin
      w_d_nxt = r_d;
      w_t_nxt = r_t;
      w_swap  = 1'b0;
      for (int i = 0; i < N-1; i++) begin
         if ((i[0] == r_cnt[0]) &&
             (r_desc ? (r_d[i] < r_d[i+1]) : (r_d[i] > r_d[i+1]))) begin
            w_d_nxt[i]   = r_d[i+1];
            w_d_nxt[i+1] = r_d[i];
            w_t_nxt[i]   = r_t[i+1];
            w_t_nxt[i+1] = r_t[i];
            w_swap       = 1'b1;
         end else begin
            w_swap = w_swap;
         end
      end
   end

   // Phase accounting: stop after two quiet phases in a row or after N phases.
   always_comb begin
      w_cnt_nxt = r_cnt + {{L{1'b0}}, 1'b1};
      w_exit    = (r_prev_zero && !w_swap) || (w_cnt_nxt == C_N);
   end

   // Control FSM, working arrays and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state               <= S_IDLE;
         r_desc                <= 1'b0;
         r_cnt                 <= {(L+1){1'b0}};
         r_prev_zero           <= 1'b0;
         distance_array_sorted <= {(W*N){1'b0}};
         type_array_sorted     <= {(TYPE_W*N){1'b0}};
         sort_cycles           <= {(L+1){1'b0}};
         valid_sort            <= 1'b0;
         busy                  <= 1'b0;
         overrun               <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_d[i] <= {W{1'b0}};
            r_t[i] <= {TYPE_W{1'b0}};
         end
      end else begin
         valid_sort <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (done_calc) begin
                  for (int i = 0; i < N; i++) begin
                     r_d[i] <= distance_array[i*W +: W];
                     r_t[i] <= type_array[i*TYPE_W +: TYPE_W];
                  end
                  r_desc      <= descend;
                  r_cnt       <= {(L+1){1'b0}};
                  r_prev_zero <= 1'b0;
                  overrun     <= 1'b0;
                  busy        <= 1'b1;
                  r_state     <= S_SORT;
               end
            end
            S_SORT: begin
               r_d         <= w_d_nxt;
               r_t         <= w_t_nxt;
               r_cnt       <= w_cnt_nxt;
               r_prev_zero <= !w_swap;
               if (done_calc) begin
                  overrun <= 1'b1;
               end
               if (w_exit) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               for (int i = 0; i < N; i++) begin
                  distance_array_sorted[i*W +: W]           <= r_d[i];
                  type_array_sorted[i*TYPE_W +: TYPE_W]     <= r_t[i];
               end
               sort_cycles <= r_cnt;
               valid_sort  <= 1'b1;
               busy        <= 1'b0;
               if (done_calc) begin
                  overrun <= 1'b1;
               end
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_distance_sort_oet.sv
// Directed and randomised checks of distance_sort_oet with L=2, W=8, TYPE_W=3.
module tb_distance_sort_oet;

   logic        clk;
   logic        rst;
   logic        done_calc;
   logic        descend;
   logic [31:0] distance_array;
   logic [11:0] type_array;
   logic [31:0] distance_array_sorted;
   logic [11:0] type_array_sorted;
   logic        valid_sort;
   logic        busy;
   logic [2:0]  sort_cycles;
   logic        overrun;

   int total;
   int bad;

   distance_sort_oet #(.L(2), .W(8), .TYPE_W(3)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .done_calc             (done_calc),
      .descend               (descend),
      .distance_array        (distance_array),
      .type_array            (type_array),
      .distance_array_sorted (distance_array_sorted),
      .type_array_sorted     (type_array_sorted),
      .valid_sort            (valid_sort),
      .busy                  (busy),
      .sort_cycles           (sort_cycles),
      .overrun               (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pd(input logic [7:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [11:0] pt(input logic [2:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   // Start a sort from idle and wait (bounded) for valid_sort.
   task automatic do_sort(input logic [31:0] d, input logic [11:0] t, input logic desc,
                          output int lat, output int bc);
      distance_array = d;
      type_array     = t;
      descend        = desc;
      done_calc      = 1'b1;
      @(posedge clk); #1;
      done_calc      = 1'b0;
      distance_array = $urandom;
      type_array     = 12'($urandom);
      descend        = ~desc;
      bc  = busy ? 1 : 0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (busy) bc++;
         if (valid_sort) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (distance_array_sorted !== 32'd0 || type_array_sorted !== 12'd0 || sort_cycles !== 3'd0 ||
          valid_sort !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got d=%h t=%h p=%0d v=%b b=%b o=%b, want all zero",
                  distance_array_sorted, type_array_sorted, sort_cycles, valid_sort, busy, overrun);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reverse();
      int lat, bc;
      do_sort(pd(8'd4, 8'd3, 8'd2, 8'd1), pt(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, lat, bc);
      total++;
      if (distance_array_sorted !== pd(8'd1, 8'd2, 8'd3, 8'd4)) begin
         bad++;
         $display("FAIL reverse_d: got %h want %h", distance_array_sorted, pd(8'd1, 8'd2, 8'd3, 8'd4));
      end
      total++;
      if (type_array_sorted !== pt(3'd4, 3'd3, 3'd2, 3'd1)) begin
         bad++;
         $display("FAIL reverse_t: got %h want %h", type_array_sorted, pt(3'd4, 3'd3, 3'd2, 3'd1));
      end
      total++;
      if (sort_cycles !== 3'd4) begin
         bad++;
         $display("FAIL reverse_p: got %0d want 4", sort_cycles);
      end
      total++;
      if (lat != 5) begin
         bad++;
         $display("FAIL reverse_latency: got %0d want 5 edges after accept", lat);
      end
      @(posedge clk); #1;
      total++;
      if (valid_sort !== 1'b0) begin
         bad++;
         $display("FAIL reverse_valid_width: got %b want 0", valid_sort);
      end
   endtask

   task automatic test_presorted();
      int lat, bc;
      do_sort(pd(8'd1, 8'd5, 8'd9, 8'd12), pt(3'd5, 3'd6, 3'd7, 3'd0), 1'b0, lat, bc);
      total++;
      if (distance_array_sorted !== pd(8'd1, 8'd5, 8'd9, 8'd12) ||
          type_array_sorted !== pt(3'd5, 3'd6, 3'd7, 3'd0)) begin
         bad++;
         $display("FAIL presorted_out: got d=%h t=%h want d=%h t=%h", distance_array_sorted,
                  type_array_sorted, pd(8'd1, 8'd5, 8'd9, 8'd12), pt(3'd5, 3'd6, 3'd7, 3'd0));
      end
      total++;
      if (sort_cycles !== 3'd2) begin
         bad++;
         $display("FAIL presorted_p: got %0d want 2", sort_cycles);
      end
      total++;
      if (bc != 3 || lat != 3) begin
         bad++;
         $display("FAIL presorted_busy: got busy=%0d lat=%0d want busy=3 lat=3", bc, lat);
      end
   endtask

   task automatic test_stable_desc();
      int lat, bc;
      do_sort(pd(8'd7, 8'd7, 8'd7, 8'd3), pt(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, lat, bc);
      total++;
      if (distance_array_sorted !== pd(8'd7, 8'd7, 8'd7, 8'd3) ||
          type_array_sorted !== pt(3'd1, 3'd2, 3'd3, 3'd4) || sort_cycles !== 3'd2) begin
         bad++;
         $display("FAIL stable_ties: got d=%h t=%h p=%0d want d=%h t=%h p=2", distance_array_sorted,
                  type_array_sorted, sort_cycles, pd(8'd7, 8'd7, 8'd7, 8'd3), pt(3'd1, 3'd2, 3'd3, 3'd4));
      end
      do_sort(pd(8'd3, 8'd9, 8'd9, 8'd1), pt(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, lat, bc);
      total++;
      if (distance_array_sorted !== pd(8'd9, 8'd9, 8'd3, 8'd1) ||
          type_array_sorted !== pt(3'd2, 3'd3, 3'd1, 3'd4)) begin
         bad++;
         $display("FAIL stable_desc: got d=%h t=%h want d=%h t=%h", distance_array_sorted,
                  type_array_sorted, pd(8'd9, 8'd9, 8'd3, 8'd1), pt(3'd2, 3'd3, 3'd1, 3'd4));
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      distance_array = pd(8'd4, 8'd3, 8'd2, 8'd1);
      type_array     = pt(3'd1, 3'd2, 3'd3, 3'd4);
      descend        = 1'b0;
      done_calc      = 1'b1;
      @(posedge clk); #1;
      done_calc = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      distance_array = pd(8'd200, 8'd0, 8'd0, 8'd0);
      type_array     = pt(3'd7, 3'd7, 3'd7, 3'd7);
      descend        = 1'b1;
      done_calc      = 1'b1;
      @(posedge clk); #1;
      done_calc = 1'b0;
      total++;
      if (overrun !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set: got overrun=%b busy=%b want 1 1", overrun, busy);
      end
      lat = -1;
      for (int k = 4; k <= 20; k++) begin
         @(posedge clk); #1;
         if (valid_sort) begin
            lat = k;
            break;
         end
      end
      total++;
      if (lat != 5 || distance_array_sorted !== pd(8'd1, 8'd2, 8'd3, 8'd4) ||
          type_array_sorted !== pt(3'd4, 3'd3, 3'd2, 3'd1) || overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_first_result: got lat=%0d d=%h t=%h o=%b want lat=5 d=%h t=%h o=1",
                  lat, distance_array_sorted, type_array_sorted, overrun,
                  pd(8'd1, 8'd2, 8'd3, 8'd4), pt(3'd4, 3'd3, 3'd2, 3'd1));
      end
      distance_array = pd(8'd5, 8'd1, 8'd4, 8'd2);
      type_array     = pt(3'd1, 3'd2, 3'd3, 3'd4);
      descend        = 1'b0;
      done_calc      = 1'b1;
      @(posedge clk); #1;
      done_calc = 1'b0;
      total++;
      if (overrun !== 1'b0 || busy !== 1'b1 || valid_sort !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept: got o=%b b=%b v=%b want 0 1 0", overrun, busy, valid_sort);
      end
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (valid_sort) begin
            lat = k;
            break;
         end
      end
      total++;
      if (lat != 5 || distance_array_sorted !== pd(8'd1, 8'd2, 8'd4, 8'd5) ||
          type_array_sorted !== pt(3'd2, 3'd4, 3'd3, 3'd1) || sort_cycles !== 3'd4) begin
         bad++;
         $display("FAIL b2b_second_result: got lat=%0d d=%h t=%h p=%0d want lat=5 d=%h t=%h p=4",
                  lat, distance_array_sorted, type_array_sorted, sort_cycles,
                  pd(8'd1, 8'd2, 8'd4, 8'd5), pt(3'd2, 3'd4, 3'd3, 3'd1));
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc, seen;
      distance_array = pd(8'd4, 8'd3, 8'd2, 8'd1);
      type_array     = pt(3'd1, 3'd2, 3'd3, 3'd4);
      descend        = 1'b0;
      done_calc      = 1'b1;
      @(posedge clk); #1;
      done_calc = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if (distance_array_sorted !== 32'd0 || type_array_sorted !== 12'd0 || sort_cycles !== 3'd0 ||
          valid_sort !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_async: got d=%h t=%h p=%0d v=%b b=%b o=%b want all zero",
                  distance_array_sorted, type_array_sorted, sort_cycles, valid_sort, busy, overrun);
      end
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (valid_sort || busy) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL reset_mid_no_valid: got %0d active cycles want 0", seen);
      end
      do_sort(pd(8'd2, 8'd0, 8'd3, 8'd1), pt(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, lat, bc);
      total++;
      if (distance_array_sorted !== pd(8'd0, 8'd1, 8'd2, 8'd3) || sort_cycles !== 3'd4 || lat != 5) begin
         bad++;
         $display("FAIL reset_mid_resort: got d=%h p=%0d lat=%0d want d=%h p=4 lat=5",
                  distance_array_sorted, sort_cycles, lat, pd(8'd0, 8'd1, 8'd2, 8'd3));
      end
   endtask

   task automatic test_random();
      int lat, bc, j;
      logic [7:0]  d [4];
      logic [7:0]  md [4];
      logic [2:0]  mt [4];
      logic [7:0]  kd;
      logic [2:0]  kt;
      logic        desc;
      logic [31:0] exp_d;
      logic [11:0] exp_t;
      for (int r = 0; r < 200; r++) begin
         for (int i = 0; i < 4; i++) begin
            d[i]  = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            md[i] = d[i];
            mt[i] = 3'(i);
         end
         desc = 1'($urandom_range(0, 1));
         for (int i = 1; i < 4; i++) begin
            kd = md[i];
            kt = mt[i];
            j  = i - 1;
            while (j >= 0 && (desc ? (kd > md[j]) : (kd < md[j]))) begin
               md[j+1] = md[j];
               mt[j+1] = mt[j];
               j--;
            end
            md[j+1] = kd;
            mt[j+1] = kt;
         end
         exp_d = pd(md[0], md[1], md[2], md[3]);
         exp_t = pt(mt[0], mt[1], mt[2], mt[3]);
         do_sort(pd(d[0], d[1], d[2], d[3]), pt(3'd0, 3'd1, 3'd2, 3'd3), desc, lat, bc);
         total++;
         if (distance_array_sorted !== exp_d || type_array_sorted !== exp_t ||
             sort_cycles < 3'd2 || sort_cycles > 3'd4 || lat != int'(sort_cycles) + 1) begin
            bad++;
            $display("FAIL random_%0d: got d=%h t=%h p=%0d lat=%0d want d=%h t=%h p in 2..4 lat=p+1",
                     r, distance_array_sorted, type_array_sorted, sort_cycles, lat, exp_d, exp_t);
         end
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b1;
      done_calc      = 1'b0;
      descend        = 1'b0;
      distance_array = 32'd0;
      type_array     = 12'd0;
      test_reset();
      test_reverse();
      test_presorted();
      test_stable_desc();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
